// File: rtl/fpall_operand_if.sv
// Operand-stage handshake bundle: upstream request side, FP-core head side, occupancy.
// The master drives requests and out_ready; the slave is the operand queue.
interface fpall_operand_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic          in_fmt;
  logic [31:0]   in_a;
  logic [31:0]   in_b;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_op;
  logic          out_fmt;
  logic [31:0]   out_a;
  logic [31:0]   out_b;
  logic [7:0]    out_cls_a;
  logic [7:0]    out_cls_b;
  logic [CW-1:0] count;

  modport master (
    output flush, in_valid, in_op, in_fmt, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_op, out_fmt, out_a, out_b,
           out_cls_a, out_cls_b, count
  );

  modport slave (
    input  flush, in_valid, in_op, in_fmt, in_a, in_b, out_ready,
    output in_ready, out_valid, out_op, out_fmt, out_a, out_b,
           out_cls_a, out_cls_b, count
  );
endinterface

// File: rtl/fpall_operand_stage.sv
// FP operand queue: classifies operands on push and stores the class flags with each entry,
// presenting the head entry to the FP core. DEPTH must be a power of two >= 2.
module fpall_operand_stage #(
  parameter int DEPTH = 2
) (
  input logic           clk,
  input logic           rst_n,
  fpall_operand_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] OP_SQRT = 2'b10;

  typedef struct packed {
    logic [1:0]  op;
    logic        fmt;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  cls_a;
    logic [7:0]  cls_b;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        wr_entry;
  entry_t        head;
  entry_t        hold;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;

  // Nibble layout {nan, inf, sub, zero} for one exponent/fraction pair.
  function automatic logic [3:0] lane_cls(input logic [7:0] e, input logic frac_nz);
    logic e_zero;
    logic e_max;
    e_zero = (e == 8'h00);
    e_max  = (e == 8'hFF);
    return {e_max & frac_nz, e_max & ~frac_nz, e_zero & frac_nz, e_zero & ~frac_nz};
  endfunction

  function automatic logic [7:0] classify(input logic [31:0] v, input logic fmt);
    if (fmt)
      return {lane_cls(v[30:23], |v[22:16]), lane_cls(v[14:7], |v[6:0])};
    return {4'h0, lane_cls(v[30:23], |v[22:0])};
  endfunction

  assign bus.in_ready  = (count_q != CW'(DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

  always_comb begin
    wr_entry       = '0;
    wr_entry.op    = bus.in_op;
    wr_entry.fmt   = bus.in_fmt;
    wr_entry.a     = bus.in_a;
    wr_entry.cls_a = classify(bus.in_a, bus.in_fmt);
    if (bus.in_op != OP_SQRT) begin
      wr_entry.b     = bus.in_b;
      wr_entry.cls_b = classify(bus.in_b, bus.in_fmt);
    end
  end

  // While empty the outputs show the last presented head rather than stale storage.
  assign head          = bus.out_valid ? mem[rd_ptr] : hold;
  assign bus.out_op    = head.op;
  assign bus.out_fmt   = head.fmt;
  assign bus.out_a     = head.a;
  assign bus.out_b     = head.b;
  assign bus.out_cls_a = head.cls_a;
  assign bus.out_cls_b = head.cls_b;
  assign bus.count     = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      hold    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (bus.out_valid) hold <= mem[rd_ptr];
      if (bus.flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= wr_entry;
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count_q <= count_q + CW'(1);
        else if (pop && !push) count_q <= count_q - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fpall_operand_stage.sv
// Randomized and directed bench for fpall_operand_stage against a queue-based reference model.
module tb_fpall_operand_stage;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [1:0]  op;
    logic        fmt;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  cls_a;
    logic [7:0]  cls_b;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  ent_t mq[$];

  fpall_operand_if #(.DEPTH(DEPTH)) bus ();

  fpall_operand_stage #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_lane(int unsigned e, int unsigned f);
    if (e == 0)   return (f == 0) ? 4'd1 : 4'd2;
    if (e == 255) return (f == 0) ? 4'd4 : 4'd8;
    return 4'd0;
  endfunction

  function automatic logic [7:0] m_cls(logic [31:0] v, logic fmt);
    int unsigned hi, lo;
    if (!fmt) return {4'h0, m_lane((v >> 23) & 32'hFF, v & 32'h7F_FFFF)};
    hi = v >> 16;
    lo = v & 32'hFFFF;
    return {m_lane((hi >> 7) & 32'hFF, hi & 32'h7F), m_lane((lo >> 7) & 32'hFF, lo & 32'h7F)};
  endfunction

  function automatic ent_t mk_entry(logic [1:0] op, logic fmt, logic [31:0] a, logic [31:0] b);
    ent_t e;
    e.op = op;  e.fmt = fmt;  e.a = a;  e.cls_a = m_cls(a, fmt);
    e.b = (op == 2'b10) ? 32'h0 : b;
    e.cls_b = (op == 2'b10) ? 8'h0 : m_cls(b, fmt);
    return e;
  endfunction

  function automatic logic [15:0] rand_half(int unsigned bits_frac);
    logic [15:0] h;
    h = 16'($urandom);
    case ($urandom_range(0, 3))
      0: h[14:7] = 8'h00;
      1: h[14:7] = 8'hFF;
      default: ;
    endcase
    if (bits_frac == 0 || $urandom_range(0, 2) == 0) h[6:0] = 7'h0;
    return h;
  endfunction

  function automatic logic [31:0] rand_val(logic fmt);
    logic [31:0] v;
    v = $urandom;
    if (fmt) return {rand_half(1), rand_half(1)};
    case ($urandom_range(0, 3))
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      default: ;
    endcase
    if ($urandom_range(0, 2) == 0) v[22:0] = 23'h0;
    return v;
  endfunction

  task automatic drive(logic v, logic [1:0] op, logic fmt, logic [31:0] a, logic [31:0] b,
                       logic ordy, logic fl);
    bus.in_valid = v;  bus.in_op = op;  bus.in_fmt = fmt;
    bus.in_a = a;  bus.in_b = b;  bus.out_ready = ordy;  bus.flush = fl;
  endtask

  // Advance one clock, updating the model from the spec's push/pop/flush rules.
  task automatic step();
    bit   do_push, do_pop, do_flush;
    ent_t e;
    do_flush = bus.flush;
    do_push  = bus.in_valid && (mq.size() < DEPTH) && !do_flush;
    do_pop   = bus.out_ready && (mq.size() > 0) && !do_flush;
    e = mk_entry(bus.in_op, bus.in_fmt, bus.in_a, bus.in_b);
    @(posedge clk);
    if (!rst_n || do_flush) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (DEPTH) step();
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL drain_empty: got out_valid=%b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 2'b01, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
    @(negedge clk);
    n_vec++;
    if ({bus.count, bus.in_ready, bus.out_valid} !== {2'd0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL reset_ctrl: got cnt=%0d rdy=%b vld=%b exp 0 1 0",
                        bus.count, bus.in_ready, bus.out_valid);
    end
    n_vec++;
    if ({bus.out_op, bus.out_fmt, bus.out_a, bus.out_b, bus.out_cls_a, bus.out_cls_b} !== 83'h0) begin
      n_err++; $display("FAIL reset_payload: got a=%h b=%h exp all zero", bus.out_a, bus.out_b);
    end
    step();
    rst_n = 1'b1;
    // First edge after release must accept a push.
    drive(1'b1, 2'b00, 1'b0, 32'h3F80_0000, 32'h7F80_0000, 1'b0, 1'b0);
    step();
    n_vec++;
    if ({bus.out_valid, bus.out_cls_a, bus.out_cls_b} !== {1'b1, 8'h00, 8'h04}) begin
      n_err++; $display("FAIL fp32_single: got vld=%b cls_a=%h cls_b=%h exp 1 00 04",
                        bus.out_valid, bus.out_cls_a, bus.out_cls_b);
    end
    n_vec++;
    if ({bus.out_a, bus.out_b} !== {32'h3F80_0000, 32'h7F80_0000}) begin
      n_err++; $display("FAIL fp32_payload: got a=%h b=%h", bus.out_a, bus.out_b);
    end
    drain();
  endtask

  task automatic test_fp16();
    drive(1'b1, 2'b01, 1'b1, 32'h0001_7FC0, 32'h3F80_0000, 1'b0, 1'b0);
    step();
    n_vec++;
    if ({bus.out_fmt, bus.out_op, bus.out_cls_a, bus.out_cls_b} !== {1'b1, 2'b01, 8'h28, 8'h01}) begin
      n_err++; $display("FAIL fp16_cls: got fmt=%b op=%b cls_a=%h cls_b=%h exp 1 01 28 01",
                        bus.out_fmt, bus.out_op, bus.out_cls_a, bus.out_cls_b);
    end
    drain();
  endtask

  task automatic test_sqrt();
    drive(1'b1, 2'b10, 1'b0, 32'h7FC0_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step();
    n_vec++;
    if ({bus.out_b, bus.out_cls_b, bus.out_cls_a} !== {32'h0, 8'h00, 8'h08}) begin
      n_err++; $display("FAIL sqrt_mask: got b=%h cls_b=%h cls_a=%h exp 0 00 08",
                        bus.out_b, bus.out_cls_b, bus.out_cls_a);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] va[3];
    va = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, 1'b0, va[i], 32'h0, 1'b0, 1'b0);
      step();
    end
    n_vec++;
    if ({bus.count, bus.in_ready} !== {2'd2, 1'b0}) begin
      n_err++; $display("FAIL full: got cnt=%0d rdy=%b exp 2 0", bus.count, bus.in_ready);
    end
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({bus.out_valid, bus.out_a} !== {1'b1, va[i]}) begin
        n_err++; $display("FAIL bp_order%0d: got vld=%b a=%h exp 1 %h", i, bus.out_valid, bus.out_a, va[i]);
      end
      step();
    end
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_third_dropped: got vld=%b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 2'b00, 1'b0, 32'hAAAA_0001, 32'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 2'b11, 1'b0, 32'hBBBB_0002, 32'h0, 1'b1, 1'b0);
    step();
    n_vec++;
    if ({bus.count, bus.out_a, bus.out_op} !== {2'd1, 32'hBBBB_0002, 2'b11}) begin
      n_err++; $display("FAIL simul: got cnt=%0d a=%h op=%b exp 1 bbbb0002 11",
                        bus.count, bus.out_a, bus.out_op);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    ent_t e;
    for (int i = 0; i < 6; i++) begin
      e = mk_entry(2'($urandom), 1'($urandom), rand_val(1'b0), rand_val(1'b0));
      drive(1'b1, e.op, e.fmt, e.a, e.b, 1'b1, 1'b0);
      step();
      e = mk_entry(e.op, e.fmt, e.a, e.b);
      n_vec++;
      if ({bus.count, bus.out_op, bus.out_fmt, bus.out_a, bus.out_b, bus.out_cls_a, bus.out_cls_b}
          !== {2'd1, e}) begin
        n_err++; $display("FAIL b2b%0d: got cnt=%0d a=%h cls=%h/%h exp 1 %h %h/%h", i, bus.count,
                          bus.out_a, bus.out_cls_a, bus.out_cls_b, e.a, e.cls_a, e.cls_b);
      end
    end
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'b00, 1'b0, 32'h5555_0000 + 32'(i), 32'h0, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 2'b01, 1'b0, 32'h6666_0000, 32'h0, 1'b1, 1'b1);
    step();
    n_vec++;
    if ({bus.count, bus.out_valid, bus.in_ready} !== {2'd0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL flush: got cnt=%0d vld=%b rdy=%b exp 0 0 1",
                        bus.count, bus.out_valid, bus.in_ready);
    end
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_drop: got vld=%b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 2'b00, 1'b0, 32'h7777_0001, 32'h0, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.out_valid, bus.count, bus.out_a} !== {1'b0, 2'd0, 32'h0}) begin
      n_err++; $display("FAIL reset_mid: got vld=%b cnt=%0d a=%h exp 0 0 0",
                        bus.out_valid, bus.count, bus.out_a);
    end
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic fmt;
    for (int cyc = 0; cyc < 600; cyc++) begin
      n_vec++;
      if ({bus.count, bus.out_valid, bus.in_ready}
          !== {2'(mq.size()), mq.size() != 0, mq.size() != DEPTH}) begin
        n_err++; $display("FAIL rand_ctrl@%0d: got cnt=%0d vld=%b rdy=%b exp cnt=%0d",
                          cyc, bus.count, bus.out_valid, bus.in_ready, mq.size());
      end
      if (mq.size() != 0) begin
        n_vec++;
        if ({bus.out_op, bus.out_fmt, bus.out_a, bus.out_b, bus.out_cls_a, bus.out_cls_b} !== mq[0]) begin
          n_err++; $display("FAIL rand_head@%0d: got op=%b a=%h b=%h cls=%h/%h exp op=%b a=%h b=%h cls=%h/%h",
                            cyc, bus.out_op, bus.out_a, bus.out_b, bus.out_cls_a, bus.out_cls_b,
                            mq[0].op, mq[0].a, mq[0].b, mq[0].cls_a, mq[0].cls_b);
        end
      end
      fmt = 1'($urandom);
      drive($urandom_range(0, 9) < 7, 2'($urandom), fmt, rand_val(fmt), rand_val(fmt),
            $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      step();
    end
  endtask

  initial begin
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_fp16();
    test_sqrt();
    test_backpressure();
    test_simultaneous();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
